// File: rtl/hermes_local_injector.sv
// Packet injector for a Hermes router LOCAL port: emits a header flit carrying the
// target address followed by req_len payload flits, under credit-based flow control.
module hermes_local_injector #(
    parameter int FLIT_SIZE = 32,
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [15:0]          req_target_i,
    input  logic [LEN_WIDTH-1:0] req_len_i,
    input  logic                 pl_valid_i,
    output logic                 pl_ready_o,
    input  logic [FLIT_SIZE-1:0] pl_data_i,
    output logic                 tx_o,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] pkt_count_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_LAST    = 2'd3
    } state_t;

    state_t                 state_r, state_nx_s;
    logic                   tx_r, tx_nx_s;
    logic                   eop_r, eop_nx_s;
    logic [FLIT_SIZE-1:0]   data_r, data_nx_s;
    logic [LEN_WIDTH-1:0]   rem_r, rem_nx_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_nx_s;
    logic                   xfer_s, req_hs_s, pl_hs_s, pl_ready_s, req_ready_s;

    // Handshake qualifiers; payload may be taken on the very edge the output register empties.
    always_comb begin
        req_ready_s = 1'b0;
        pl_ready_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            req_ready_s = ~rst_i;
        end else if ((state_r == ST_HDR || state_r == ST_PAYLOAD) && rem_r != LEN_ZERO) begin
            pl_ready_s = ~tx_r | credit_i;
        end else begin
            pl_ready_s = 1'b0;
        end
        xfer_s   = tx_r & credit_i;
        req_hs_s = req_valid_i & req_ready_s;
        pl_hs_s  = pl_valid_i & pl_ready_s;
    end

    // Next-state and next output-flit computation.
    always_comb begin
        state_nx_s = state_r;
        tx_nx_s    = tx_r;
        eop_nx_s   = eop_r;
        data_nx_s  = data_r;
        rem_nx_s   = rem_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    rem_nx_s   = req_len_i;
                    data_nx_s  = {{(FLIT_SIZE-16){1'b0}}, req_target_i};
                    tx_nx_s    = 1'b1;
                    eop_nx_s   = (req_len_i == LEN_ZERO);
                    state_nx_s = ST_HDR;
                end else begin
                    tx_nx_s = 1'b0;
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (state_r == ST_HDR && xfer_s && eop_r) begin
                    tx_nx_s    = 1'b0;
                    eop_nx_s   = 1'b0;
                    cnt_nx_s   = cnt_r + CNT_ONE;
                    state_nx_s = ST_IDLE;
                end else if (pl_hs_s) begin
                    data_nx_s  = pl_data_i;
                    tx_nx_s    = 1'b1;
                    eop_nx_s   = (rem_r == LEN_ONE);
                    rem_nx_s   = rem_r - LEN_ONE;
                    state_nx_s = (rem_r == LEN_ONE) ? ST_LAST : ST_PAYLOAD;
                end else if (xfer_s) begin
                    tx_nx_s    = 1'b0;
                    state_nx_s = ST_PAYLOAD;
                end else begin
                    tx_nx_s = tx_r;
                end
            end
            ST_LAST: begin
                if (xfer_s) begin
                    tx_nx_s    = 1'b0;
                    eop_nx_s   = 1'b0;
                    cnt_nx_s   = cnt_r + CNT_ONE;
                    state_nx_s = ST_IDLE;
                end else begin
                    tx_nx_s = tx_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                tx_nx_s    = 1'b0;
                eop_nx_s   = 1'b0;
            end
        endcase
    end

    // State and output-flit registers; reset drops any packet in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b0;
            eop_r   <= 1'b0;
            data_r  <= {FLIT_SIZE{1'b0}};
            rem_r   <= {LEN_WIDTH{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nx_s;
            tx_r    <= tx_nx_s;
            eop_r   <= eop_nx_s;
            data_r  <= data_nx_s;
            rem_r   <= rem_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    assign req_ready_o = req_ready_s;
    assign pl_ready_o  = pl_ready_s;
    assign tx_o        = tx_r;
    assign eop_o       = eop_r;
    assign data_o      = data_r;
    assign busy_o      = (state_r != ST_IDLE);
    assign pkt_count_o = cnt_r;

endmodule

// File: tb/tb_hermes_local_injector.sv
// Directed bench for hermes_local_injector: cycle table for whole packets plus
// hand-written reset sequences.
module tb_hermes_local_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [15:0] req_target, req_len;
    logic        pl_valid, pl_ready;
    logic [31:0] pl_data;
    logic        tx, eop, credit, busy;
    logic [31:0] data;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    hermes_local_injector #(.FLIT_SIZE(32), .LEN_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_target_i(req_target), .req_len_i(req_len),
        .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_data_i(pl_data),
        .tx_o(tx), .eop_o(eop), .data_o(data), .credit_i(credit),
        .busy_o(busy), .pkt_count_o(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [15:0] tgt;
        logic [15:0] len;
        logic        pv;
        logic [31:0] pd;
        logic        cr;
        logic        e_tx;
        logic        e_eop;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_rr;
        logic        e_pr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rv, input logic [15:0] tgt, input logic [15:0] len,
                                input logic pv, input logic [31:0] pd, input logic cr,
                                input logic e_tx, input logic e_eop, input logic [31:0] e_data,
                                input logic e_busy, input logic e_rr, input logic e_pr,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.rv = rv; v.tgt = tgt; v.len = len; v.pv = pv; v.pd = pd; v.cr = cr;
        v.e_tx = e_tx; v.e_eop = e_eop; v.e_data = e_data; v.e_busy = e_busy;
        v.e_rr = e_rr; v.e_pr = e_pr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [15:0] tgt, input logic [15:0] len,
                         input logic pv, input logic [31:0] pd, input logic cr);
        req_valid = rv; req_target = tgt; req_len = len;
        pl_valid = pv; pl_data = pd; credit = cr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        #3;
        chk("rst_tx", {31'd0, tx}, 32'd0);
        chk("rst_eop", {31'd0, eop}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, pkt_count}, 32'd0);
        chk("rst_plr", {31'd0, pl_ready}, 32'd0);
        #9 rst = 1'b0;
        next_cycle();
        chk("rel_reqready", {31'd0, req_ready}, 32'd1);

        // rv tgt len pv pd cr | tx eop data busy rr pr cnt
        // basic packet, len 3, full credit
        vq.push_back(mk(1, 16'h0102, 16'd3, 0, 32'h0, 1,  0, 0, 32'h0,   0, 1, 0, 16'd0));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hA, 1,  1, 0, 32'h102, 1, 0, 1, 16'd0));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hB, 1,  1, 0, 32'hA,   1, 0, 1, 16'd0));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hC, 1,  1, 0, 32'hB,   1, 0, 1, 16'd0));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hD, 1,  1, 1, 32'hC,   1, 0, 0, 16'd0));
        vq.push_back(mk(0, 16'h0,    16'd0, 0, 32'h0, 1,  0, 0, 32'h0,   0, 1, 0, 16'd1));
        // backpressure: header stalled 3 cycles
        vq.push_back(mk(1, 16'h0102, 16'd3, 0, 32'h0, 1,  0, 0, 32'h0,   0, 1, 0, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hA, 0,  1, 0, 32'h102, 1, 0, 0, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hA, 0,  1, 0, 32'h102, 1, 0, 0, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hA, 0,  1, 0, 32'h102, 1, 0, 0, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hA, 1,  1, 0, 32'h102, 1, 0, 1, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hB, 1,  1, 0, 32'hA,   1, 0, 1, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'hC, 1,  1, 0, 32'hB,   1, 0, 1, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 0, 32'h0, 1,  1, 1, 32'hC,   1, 0, 0, 16'd1));
        vq.push_back(mk(0, 16'h0,    16'd0, 0, 32'h0, 1,  0, 0, 32'h0,   0, 1, 0, 16'd2));
        // zero-length packet, payload offered throughout must be ignored
        vq.push_back(mk(1, 16'h0300, 16'd0, 1, 32'h55, 1, 0, 0, 32'h0,   0, 1, 0, 16'd2));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'h55, 0, 1, 1, 32'h300, 1, 0, 0, 16'd2));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'h55, 1, 1, 1, 32'h300, 1, 0, 0, 16'd2));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'h55, 1, 0, 0, 32'h0,   0, 1, 0, 16'd3));
        // payload starvation, len 2
        vq.push_back(mk(1, 16'h0203, 16'd2, 0, 32'h0, 1,  0, 0, 32'h0,   0, 1, 0, 16'd3));
        vq.push_back(mk(0, 16'h0,    16'd0, 0, 32'h0, 1,  1, 0, 32'h203, 1, 0, 1, 16'd3));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 16'h0, 16'd0, 0, 32'h0, 1, 0, 0, 32'h0,   1, 0, 1, 16'd3));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'h11, 1, 0, 0, 32'h0,   1, 0, 1, 16'd3));
        vq.push_back(mk(0, 16'h0,    16'd0, 1, 32'h22, 1, 1, 0, 32'h11,  1, 0, 1, 16'd3));
        vq.push_back(mk(0, 16'h0,    16'd0, 0, 32'h0, 1,  1, 1, 32'h22,  1, 0, 0, 16'd3));
        vq.push_back(mk(0, 16'h0,    16'd0, 0, 32'h0, 1,  0, 0, 32'h0,   0, 1, 0, 16'd4));

        foreach (vq[i]) begin
            drive(vq[i].rv, vq[i].tgt, vq[i].len, vq[i].pv, vq[i].pd, vq[i].cr);
            #1;
            chk($sformatf("v%0d_tx", i), {31'd0, tx}, {31'd0, vq[i].e_tx});
            chk($sformatf("v%0d_eop", i), {31'd0, eop}, {31'd0, vq[i].e_eop});
            if (vq[i].e_tx)
                chk($sformatf("v%0d_data", i), data, vq[i].e_data);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vq[i].e_busy});
            chk($sformatf("v%0d_reqready", i), {31'd0, req_ready}, {31'd0, vq[i].e_rr});
            chk($sformatf("v%0d_plready", i), {31'd0, pl_ready}, {31'd0, vq[i].e_pr});
            chk($sformatf("v%0d_cnt", i), {16'd0, pkt_count}, {16'd0, vq[i].e_cnt});
            next_cycle();
        end

        // reset mid-packet after the first of 4 payload flits
        drive(1'b1, 16'h0506, 16'd4, 1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 16'h0, 16'd0, 1'b1, 32'h77, 1'b1);
        next_cycle();
        chk("mid_data", data, 32'h77);
        chk("mid_tx", {31'd0, tx}, 32'd1);
        drive(1'b0, 16'h0, 16'd0, 1'b0, 32'h0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd0);
        chk("mid_rst_eop", {31'd0, eop}, 32'd0);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cnt", {16'd0, pkt_count}, 32'd0);
        chk("mid_rst_plr", {31'd0, pl_ready}, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("mid_rel_reqready", {31'd0, req_ready}, 32'd1);
        chk("mid_rel_tx", {31'd0, tx}, 32'd0);
        next_cycle();

        // clean packet after reset: len 1, target 0x0405
        drive(1'b1, 16'h0405, 16'd1, 1'b0, 32'h0, 1'b1);
        next_cycle();
        drive(1'b0, 16'h0, 16'd0, 1'b1, 32'h99, 1'b1);
        #1;
        chk("post_hdr_data", data, 32'h405);
        chk("post_hdr_eop", {31'd0, eop}, 32'd0);
        chk("post_hdr_tx", {31'd0, tx}, 32'd1);
        next_cycle();
        drive(1'b0, 16'h0, 16'd0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("post_pl_data", data, 32'h99);
        chk("post_pl_eop", {31'd0, eop}, 32'd1);
        next_cycle();
        chk("post_cnt", {16'd0, pkt_count}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
